minibus_ram_slave: RTL

Minibus responder fronting a single-port word-organised RAM. It accepts one read or write request at a time from a minibus master, such as the datapath memory controller. It applies a fixed access latency and returns a single-cycle registered acknowledge carrying read data or an error flag. It is the terminating device for the instruction/data memory region on the minibus.

---
 rtl/minibus_pkg.sv | 26 ++
 rtl/minibus_slave_if.sv | 12 +
 rtl/minibus_lane_align.sv | 44 ++++
 rtl/minibus_ram_slave.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/minibus_pkg.sv
// Shared minibus types: access widths and the request/response bundles.
// Used by the bus interface, the RAM responder and its lane logic.
package minibus_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } minibus_width_t;

    // width is kept as raw bits so the illegal 2'b11 code can be carried and rejected
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        ren;
        logic [1:0]  width;
    } minibus_req_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        error;
    } minibus_res_t;

endpackage

// File: rtl/minibus_slave_if.sv
// Minibus request/response bundle between one master and one responder.
// The master drives req; the responder drives res.
interface minibus_slave_if;
    import minibus_pkg::*;

    minibus_req_t req;
    minibus_res_t res;

    modport master (output req, input res);
    modport slave  (input req, output res);

endinterface

// File: rtl/minibus_lane_align.sv
// Byte-lane steering for a 32-bit word RAM behind the minibus.
// Produces lane enables, shifted store data, load shift/mask and a bad-access flag.
module minibus_lane_align
    import minibus_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [4:0]  rshift,
    output logic [31:0] rmask,
    output logic        misalign
);

    // Lane enables, load mask and alignment check for each access width.
    always_comb begin
        byte_en  = 4'b0000;
        rmask    = 32'h0000_0000;
        misalign = 1'b1;
        case (width)
            BYTE: begin
                byte_en  = 4'b0001 << offset;
                rmask    = 32'h0000_00ff;
                misalign = 1'b0;
            end
            HALF: begin
                byte_en  = 4'b0011 << offset;
                rmask    = 32'h0000_ffff;
                misalign = offset[0];
            end
            WORD: begin
                byte_en  = 4'b1111;
                rmask    = 32'hffff_ffff;
                misalign = |offset;
            end
            default: ;
        endcase
    end

    assign rshift   = {offset, 3'b000};
    assign wdata_sh = wdata << rshift;

endmodule

// File: rtl/minibus_ram_slave.sv
// Minibus responder for a word-organised RAM with a fixed access latency.
// One request at a time; a single-cycle registered ack carries rdata/error.
module minibus_ram_slave
    import minibus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic              CLK,
    input logic              nRST,
    minibus_slave_if.slave   _sif
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = $clog2(16);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_width;
    logic        r_wr;

    logic        ack_q;
    logic        error_q;
    logic [31:0] rdata_q;

    logic        req_v;
    logic        commit;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_width;
    logic        a_wr;
    logic [31:0] off;
    logic        err;
    logic        misalign;
    logic [3:0]  byte_en;
    logic [31:0] wdata_sh;
    logic [4:0]  rshift;
    logic [31:0] rmask;
    logic [31:0] rword;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_v = _sif.req.wen | _sif.req.ren;

    // With LATENCY==1 the access happens on the accept edge, so use the live request.
    assign a_addr  = (state == IDLE) ? _sif.req.addr  : r_addr;
    assign a_wdata = (state == IDLE) ? _sif.req.wdata : r_wdata;
    assign a_width = (state == IDLE) ? _sif.req.width : r_width;
    assign a_wr    = (state == IDLE) ? _sif.req.wen   : r_wr;

    assign off   = a_addr - BASE_ADDR;
    assign idx   = off[AW+1:2];
    assign err   = misalign | ({1'b0, off} >= SPAN);
    assign rword = mem[idx];

    assign commit = (state_n == RESP);

    minibus_lane_align u_lane (
        .width    (a_width),
        .offset   (off[1:0]),
        .wdata    (a_wdata),
        .byte_en  (byte_en),
        .wdata_sh (wdata_sh),
        .rshift   (rshift),
        .rmask    (rmask),
        .misalign (misalign)
    );

    // State register and latency countdown.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE:    if (req_v) cnt <= CW'(LATENCY - 1);
                WAIT:    cnt <= cnt - CW'(1);
                default: cnt <= '0;
            endcase
        end
    end

    // Next-state: accept in IDLE, count down in WAIT, one ack cycle in RESP.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_v) state_n = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == CW'(1)) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Capture the request on acceptance; later changes on the bus are ignored.
    always_ff @(posedge CLK) begin
        if (state == IDLE && req_v) begin
            r_addr  <= _sif.req.addr;
            r_wdata <= _sif.req.wdata;
            r_width <= _sif.req.width;
            r_wr    <= _sif.req.wen;
        end
    end

    // Response registers: loaded on the commit edge, cleared otherwise.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ack_q   <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= commit;
            error_q <= commit & err;
            rdata_q <= (commit && !err && !a_wr) ? ((rword >> rshift) & rmask) : '0;
        end
    end

    // Lane-masked RAM write; reset on the commit edge suppresses it.
    always_ff @(posedge CLK) begin
        if (nRST && commit && a_wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // Bus outputs come straight from registers.
    always_comb begin
        _sif.res.ack   = ack_q;
        _sif.res.rdata = rdata_q;
        _sif.res.error = error_q;
    end

endmodule
